// File: rtl/stage_sequencer.sv
// ============================================================================
// Module      : stage_sequencer
// Description : Multi-cycle IF/ID/EX/MEM/WB controller for the non-pipelined
//               core. Owns the architectural PC, drives next_pc to fetch,
//               handles branch redirect, data-memory wait with timeout, halt.
//               Optional build macro SKIP_MEM_EN: non-memory instructions
//               bypass MEM (EX -> WB, 4 cycles per instruction).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stage_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h00008000,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        is_mem,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        mem_ready,
  input  logic        halt_req,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        exec_en,
  output logic        mem_en,
  output logic        wb_en,
  output logic [31:0] next_pc,
  output logic [31:0] pc,
  output logic [2:0]  stage,
  output logic        mem_timeout_err,
  output logic        halted,
  output logic [31:0] retired_cnt
);

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_t;

  // Last wait-counter value allowed before a MEM access is declared timed out.
  localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

  state_t      state;
  state_t      state_nx;
  logic        lat_is_mem;
  logic        lat_taken;
  logic [31:0] lat_target;
  logic [15:0] wait_cnt;
  logic [31:0] pc_reg;
  logic [31:0] next_pc_reg;
  logic [31:0] retired_reg;
  logic        err_reg;
  logic        timeout_hit;
  logic        mem_waiting;
  logic [31:0] pc_after_wb;

  // PC of the following instruction: redirect target or sequential successor.
  assign pc_after_wb = lat_taken ? lat_target : (pc_reg + 32'd4);

  // Next-state selection and one-hot stage-enable decode.
  always_comb begin
    state_nx    = state;
    timeout_hit = 1'b0;
    mem_waiting = 1'b0;
    fetch_en    = 1'b0;
    decode_en   = 1'b0;
    exec_en     = 1'b0;
    mem_en      = 1'b0;
    wb_en       = 1'b0;
    case (state)
      ST_IF: begin
        fetch_en = 1'b1;
        state_nx = ST_ID;
      end
      ST_ID: begin
        decode_en = 1'b1;
        state_nx  = ST_EX;
      end
      ST_EX: begin
        exec_en = 1'b1;
`ifdef SKIP_MEM_EN
        state_nx = lat_is_mem ? ST_MEM : ST_WB;
`else
        state_nx = ST_MEM;
`endif
      end
      ST_MEM: begin
        mem_en = 1'b1;
        if (!lat_is_mem || mem_ready) begin
          state_nx = ST_WB;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nx    = ST_WB;
          timeout_hit = 1'b1;
        end else begin
          mem_waiting = 1'b1;
        end
      end
      ST_WB: begin
        wb_en    = 1'b1;
        state_nx = halt_req ? ST_HALT : ST_IF;
      end
      ST_HALT: begin
        state_nx = ST_HALT;
      end
      default: begin
        state_nx = ST_IF;
      end
    endcase
  end

  // State register, per-instruction latches, PC, retire count and sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IF;
      lat_is_mem  <= 1'b0;
      lat_taken   <= 1'b0;
      lat_target  <= 32'd0;
      wait_cnt    <= 16'd0;
      pc_reg      <= RESET_PC;
      next_pc_reg <= RESET_PC;
      retired_reg <= 32'd0;
      err_reg     <= 1'b0;
    end else begin
      state <= state_nx;

      if (state == ST_ID) begin
        lat_is_mem <= is_mem;
      end

      if (state == ST_EX) begin
        lat_taken  <= branch_taken;
        lat_target <= {branch_target[31:2], 2'b00};
      end

      // Counter only runs while stalled in MEM; any other stage clears it,
      // so every MEM entry starts from zero.
      if (mem_waiting) begin
        wait_cnt <= wait_cnt + 16'd1;
      end else begin
        wait_cnt <= 16'd0;
      end

      if (timeout_hit) begin
        err_reg <= 1'b1;
      end

      if (state == ST_WB) begin
        pc_reg      <= pc_after_wb;
        next_pc_reg <= pc_after_wb;
        retired_reg <= retired_reg + 32'd1;
      end
    end
  end

  assign stage           = state;
  assign pc              = pc_reg;
  assign next_pc         = next_pc_reg;
  assign retired_cnt     = retired_reg;
  assign mem_timeout_err = err_reg;
  assign halted          = (state == ST_HALT);

endmodule

`default_nettype wire

// File: tb/tb_stage_sequencer.sv
// ============================================================================
// Module      : tb_stage_sequencer
// Description : Self-checking bench for stage_sequencer. Each instruction is
//               described as a transaction; the expected per-cycle stage list,
//               PC, retire count and error flag come from a transaction-level
//               model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stage_sequencer;

  localparam logic [31:0] RPC = 32'h00008000;
  localparam int          MT  = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        is_mem = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        mem_ready = 1'b0;
  logic        halt_req = 1'b0;
  logic        fetch_en, decode_en, exec_en, mem_en, wb_en;
  logic [31:0] next_pc, pc, retired_cnt;
  logic [2:0]  stage;
  logic        mem_timeout_err, halted;

  int          checks = 0;
  int          errors = 0;

  logic [31:0] exp_pc;
  logic [31:0] exp_ret;
  logic        exp_err;

  stage_sequencer #(
    .RESET_PC    (RPC),
    .MEM_TIMEOUT (MT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .is_mem          (is_mem),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .mem_ready       (mem_ready),
    .halt_req        (halt_req),
    .fetch_en        (fetch_en),
    .decode_en       (decode_en),
    .exec_en         (exec_en),
    .mem_en          (mem_en),
    .wb_en           (wb_en),
    .next_pc         (next_pc),
    .pc              (pc),
    .stage           (stage),
    .mem_timeout_err (mem_timeout_err),
    .halted          (halted),
    .retired_cnt     (retired_cnt)
  );

  always #5 clk = ~clk;

  // Global time limit so the run can never hang.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic drive_random();
    is_mem        = 1'($urandom);
    branch_taken  = 1'($urandom);
    branch_target = $urandom;
    mem_ready     = 1'($urandom);
    halt_req      = 1'($urandom);
  endtask

  // One instruction as a transaction. ready_at = MEM cycle (1-based) on which
  // mem_ready is high; 0 or > MT means never (timeout).
  task automatic run_instr(input bit im, input int ready_at, input bit bt,
                           input logic [31:0] tgt, input bit hr, input string tag);
    int          n_mem;
    bit          tmo;
    int          q[$];
    int          mem_idx;
    logic [4:0]  onehot;
    tmo = 1'b0;
    if (!im) begin
`ifdef SKIP_MEM_EN
      n_mem = 0;
`else
      n_mem = 1;
`endif
    end else if (ready_at >= 1 && ready_at <= MT) begin
      n_mem = ready_at;
    end else begin
      n_mem = MT;
      tmo   = 1'b1;
    end
    q = {0, 1, 2};
    repeat (n_mem) q.push_back(3);
    q.push_back(4);
    mem_idx = 0;
    for (int k = 0; k < q.size(); k++) begin
      int s;
      s      = q[k];
      onehot = 5'b10000 >> s;
      checks++;
      if (stage !== 3'(s)) begin
        errors++;
        $display("FAIL %s stage cyc=%0d got=%0d exp=%0d", tag, k, stage, s);
      end
      checks++;
      if ({fetch_en, decode_en, exec_en, mem_en, wb_en} !== onehot) begin
        errors++;
        $display("FAIL %s enables cyc=%0d got=%b exp=%b", tag, k,
                 {fetch_en, decode_en, exec_en, mem_en, wb_en}, onehot);
      end
      checks++;
      if (pc !== exp_pc || next_pc !== exp_pc) begin
        errors++;
        $display("FAIL %s pc cyc=%0d got pc=%h next_pc=%h exp=%h", tag, k, pc, next_pc, exp_pc);
      end
      checks++;
      if (retired_cnt !== exp_ret) begin
        errors++;
        $display("FAIL %s retired cyc=%0d got=%0d exp=%0d", tag, k, retired_cnt, exp_ret);
      end
      checks++;
      if (mem_timeout_err !== exp_err || halted !== 1'b0) begin
        errors++;
        $display("FAIL %s err/halted cyc=%0d got err=%b halted=%b exp err=%b halted=0",
                 tag, k, mem_timeout_err, halted, exp_err);
      end
      // Inputs outside their sampling stage are randomized to show they are ignored.
      drive_random();
      if (s == 1) is_mem = im;
      if (s == 2) begin
        branch_taken  = bt;
        branch_target = tgt;
      end
      if (s == 3) begin
        mem_idx++;
        if (im) mem_ready = (ready_at >= 1) && (mem_idx >= ready_at);
      end
      if (s == 4) halt_req = hr;
      @(negedge clk);
      if (tmo && s == 3 && mem_idx == MT) exp_err = 1'b1;
    end
    exp_pc  = bt ? {tgt[31:2], 2'b00} : exp_pc + 32'd4;
    exp_ret = exp_ret + 32'd1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (stage !== 3'd0 || pc !== RPC || next_pc !== RPC || retired_cnt !== 32'd0 ||
          mem_timeout_err !== 1'b0 || halted !== 1'b0 ||
          {fetch_en, decode_en, exec_en, mem_en, wb_en} !== 5'b10000) begin
        errors++;
        $display("FAIL reset_state got stage=%0d pc=%h npc=%h ret=%0d err=%b h=%b en=%b exp 0/%h/%h/0/0/0/10000",
                 stage, pc, next_pc, retired_cnt, mem_timeout_err, halted,
                 {fetch_en, decode_en, exec_en, mem_en, wb_en}, RPC, RPC);
      end
      drive_random();
      @(negedge clk);
    end
    reset   = 1'b1;
    exp_pc  = RPC;
    exp_ret = 32'd0;
    exp_err = 1'b0;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) run_instr(1'b0, 0, 1'b0, 32'd0, 1'b0, "seq");
    checks++;
    if (retired_cnt !== 32'd3 || next_pc !== 32'h0000800C) begin
      errors++;
      $display("FAIL seq_after3 got ret=%0d npc=%h exp ret=3 npc=0000800c", retired_cnt, next_pc);
    end
  endtask

  task automatic test_branch();
    run_instr(1'b0, 0, 1'b1, 32'h00009003, 1'b0, "branch");
    checks++;
    if (pc !== 32'h00009000 || next_pc !== 32'h00009000) begin
      errors++;
      $display("FAIL branch_target got pc=%h npc=%h exp 00009000", pc, next_pc);
    end
    run_instr(1'b1, 1, 1'b1, 32'hFFFFFFFE, 1'b0, "branch_hi");
    run_instr(1'b0, 0, 1'b0, 32'd0, 1'b0, "pc_wrap");
    checks++;
    if (pc !== 32'd0) begin
      errors++;
      $display("FAIL pc_wrap got pc=%h exp 00000000", pc);
    end
    run_instr(1'b0, 0, 1'b1, 32'h00008100, 1'b0, "branch_back");
  endtask

  task automatic test_mem_wait();
    run_instr(1'b1, 3, 1'b0, 32'd0, 1'b0, "mem_wait3");
    run_instr(1'b1, 1, 1'b0, 32'd0, 1'b0, "mem_wait1");
    run_instr(1'b1, MT, 1'b0, 32'd0, 1'b0, "mem_waitmax");
  endtask

  task automatic test_timeout();
    run_instr(1'b1, 0, 1'b0, 32'd0, 1'b0, "timeout");
    run_instr(1'b0, 0, 1'b0, 32'd0, 1'b0, "err_sticky");
    run_instr(1'b1, 2, 1'b0, 32'd0, 1'b0, "err_sticky_mem");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_instr(1'($urandom), int'($urandom_range(0, MT + 2)),
                ($urandom_range(0, 3) == 0), $urandom, 1'b0, "random");
    end
  endtask

  task automatic test_reset_mid_mem();
    // IF, ID (is_mem=1), EX, then stall in MEM with mem_ready low.
    drive_random();
    @(negedge clk);
    drive_random(); is_mem = 1'b1;
    @(negedge clk);
    drive_random(); branch_taken = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      drive_random(); mem_ready = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (stage !== 3'd3) begin
      errors++;
      $display("FAIL mid_mem_pre got stage=%0d exp=3", stage);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (stage !== 3'd0 || pc !== RPC || next_pc !== RPC || retired_cnt !== 32'd0 ||
        mem_timeout_err !== 1'b0 || {fetch_en, decode_en, exec_en, mem_en, wb_en} !== 5'b10000) begin
      errors++;
      $display("FAIL mid_mem_reset got stage=%0d pc=%h npc=%h ret=%0d err=%b en=%b exp 0/%h/%h/0/0/10000",
               stage, pc, next_pc, retired_cnt, mem_timeout_err,
               {fetch_en, decode_en, exec_en, mem_en, wb_en}, RPC, RPC);
    end
    @(negedge clk);
    reset   = 1'b1;
    exp_pc  = RPC;
    exp_ret = 32'd0;
    exp_err = 1'b0;
    run_instr(1'b0, 0, 1'b0, 32'd0, 1'b0, "after_reset");
    run_instr(1'b1, 2, 1'b0, 32'd0, 1'b0, "after_reset_mem");
  endtask

  task automatic test_halt();
    run_instr(1'b0, 0, 1'b1, 32'h00001235, 1'b1, "halt");
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (stage !== 3'd5 || halted !== 1'b1 ||
          {fetch_en, decode_en, exec_en, mem_en, wb_en} !== 5'b00000 ||
          pc !== 32'h00001234 || next_pc !== 32'h00001234 || retired_cnt !== exp_ret) begin
        errors++;
        $display("FAIL halt_frozen cyc=%0d got stage=%0d h=%b en=%b pc=%h npc=%h ret=%0d exp 5/1/00000/00001234/00001234/%0d",
                 c, stage, halted, {fetch_en, decode_en, exec_en, mem_en, wb_en},
                 pc, next_pc, retired_cnt, exp_ret);
      end
      drive_random();
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_random();
    test_reset_mid_mem();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Multi-cycle controller for the non-pipelined core.
- Steps each instruction through IF/ID/EX/MEM/WB and generates one stage-enable strobe per stage.
- Owns the architectural PC and drives next_pc into the fetch stage's instruction-memory lookup.
- Handles branch redirect, data-memory wait handshake with timeout, and halt.

Parameters:
- RESET_PC, 32'h00008000, PC and next_pc value after reset.
- MEM_TIMEOUT, 16, max cycles spent in MEM waiting for mem_ready (range 2..65535).

Ports:
- clk  input  1  system clock, all state on posedge
- reset  input  1  asynchronous, active-low reset (reset==0 resets immediately, independent of clk)
- is_mem  input  1  decoded instruction is load/store; sampled on the ID cycle
- branch_taken  input  1  control transfer taken; sampled on the EX cycle
- branch_target  input  32  redirect address; sampled on the EX cycle
- mem_ready  input  1  data memory/UART access complete; sampled in MEM
- halt_req  input  1  stop after current instruction; sampled on the WB cycle
- fetch_en  output  1  high during IF
- decode_en  output  1  high during ID
- exec_en  output  1  high during EX
- mem_en  output  1  high during MEM
- wb_en  output  1  high during WB; register-file write permitted only here
- next_pc  output  32  address presented to fetch
- pc  output  32  PC of instruction in flight
- stage  output  3  IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5
- mem_timeout_err  output  1  sticky; set on MEM timeout
- halted  output  1  high in HALT
- retired_cnt  output  32  instructions completed

Behaviour:
- Reset (async, reset==0):
  - stage=IF, pc=next_pc=RESET_PC.
  - retired_cnt=0, mem_timeout_err=0, halted=0.
  - Latched is_mem/branch state cleared, wait counter=0.
  - Enables are decoded from stage, so fetch_en=1 and all other enables are 0 during reset.
- Enables are combinational one-hot decodes of stage. In HALT all enables are 0.
- IF -> ID -> EX unconditionally, 1 cycle each.
- ID cycle: latch is_mem.
- EX cycle: latch branch_taken; latch branch_target with bits [1:0] forced to 00.
- EX -> MEM, always (base build).
- MEM, latched is_mem=0: exactly 1 cycle; mem_ready ignored.
- MEM, latched is_mem=1:
  - If mem_ready=1, go to WB next cycle, including the first MEM cycle (1-cycle minimum).
  - Otherwise increment the wait counter.
  - When counter reaches MEM_TIMEOUT-1 with mem_ready still 0: set mem_timeout_err, go to WB. Err stays set until reset.
  - Wait counter clears on MEM entry.
- WB cycle, on the posedge leaving WB:
  - pc and next_pc <= latched_taken ? latched_target : pc+4 (mod 2^32; 32'hFFFFFFFC+4 = 0).
  - retired_cnt += 1 (wraps at 2^32).
  - If halt_req=1: stage <= HALT, halted=1. Otherwise stage <= IF.
- next_pc changes only at WB exit, so fetch sees a stable address for the whole next instruction.
- HALT is terminal until reset. All inputs ignored; pc, next_pc and retired_cnt frozen.
- Base latency: 5 cycles/instruction plus (MEM wait cycles - 1) for memory ops.
- Reset mid-instruction (any stage, incl. MEM wait): abandon the instruction, no retirement, return to reset state asynchronously.
- Simultaneous halt_req and branch_taken: the redirect still updates pc/next_pc, then HALT.

Optional Feature:
- Macro SKIP_MEM_EN.
- When defined, a non-memory instruction (latched is_mem=0) goes EX -> WB directly (4 cycles/instr) and mem_en never asserts for it.
- Memory instructions behave as in the base build.
- When undefined, every instruction visits MEM as specified above.

Test Plan:
- Release reset, is_mem=0, branch_taken=0, 3 instructions -> stage sequence 0,1,2,3,4 repeating; next_pc 0x8000 -> 0x8004 -> 0x8008 -> 0x800C; retired_cnt=3 after 15 cycles.
- EX with branch_taken=1, branch_target=0x00009003 -> after WB, pc=next_pc=0x00009000.
- is_mem=1, mem_ready rises on 3rd MEM cycle -> MEM lasts 3 cycles, mem_en high for all 3; err stays 0.
- is_mem=1, mem_ready held 0, MEM_TIMEOUT=16 -> WB after 16 MEM cycles; mem_timeout_err=1 and remains 1 across later instructions.
- halt_req=1 on WB -> stage=5, halted=1, all enables 0, pc frozen for 20 further cycles.
- Assert reset mid-MEM wait -> immediately stage=0, pc=next_pc=0x8000, retired_cnt=0.
- With SKIP_MEM_EN defined: non-mem instruction takes 4 cycles, mem_en never asserted.
